// File: rtl/regfile_read_sched_pkg.sv
// Shared constants and types for the register-file read scheduler: widths,
// RV32I opcodes, instruction classes and scheduler FSM states.
package regfile_sched_pkg;

  localparam int WORD_SIZE  = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_SB,
    CLS_UJ,
    CLS_ILL
  } instr_class_t;

  typedef enum logic [2:0] {
    IDLE,
    RS1_RD,
    RS1_CAP,
    RS2_RD,
    RS2_CAP,
    OUT
  } sched_state_t;

  function automatic logic class_has_rd(input instr_class_t cls);
    return (cls == CLS_R) || (cls == CLS_I) || (cls == CLS_UJ);
  endfunction

endpackage

// File: rtl/regfile_read_sched_instr_field_decode.sv
// Combinational RV32I field decode: opcode class, register fields and which
// source reads are actually needed (used and nonzero).
module instr_field_decode
  import regfile_sched_pkg::*;
(
  input  logic [WORD_SIZE-1:0]  instruction,
  output instr_class_t          cls,
  output logic [REG_ADDR_W-1:0] rs1,
  output logic [REG_ADDR_W-1:0] rs2,
  output logic [REG_ADDR_W-1:0] rd,
  output logic                  need_rs1,
  output logic                  need_rs2,
  output logic                  illegal
);

  logic       uses_rs1;
  logic       uses_rs2;
  logic [6:0] opcode;
  logic       unused_bits;

  assign opcode      = instruction[6:0];
  assign rs1         = instruction[19:15];
  assign rs2         = instruction[24:20];
  assign rd          = instruction[11:7];
  assign unused_bits = ^{instruction[31:25], instruction[14:12]};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cls = CLS_ILL;
    case (opcode)
      OPC_OP:                           cls = CLS_R;
      OPC_OP_IMM, OPC_JALR, OPC_LOAD:   cls = CLS_I;
      OPC_STORE, OPC_BRANCH:            cls = CLS_SB;
      OPC_LUI, OPC_AUIPC, OPC_JAL:      cls = CLS_UJ;
      default:                          cls = CLS_ILL;
    endcase
  end

  assign uses_rs1 = (cls == CLS_R) || (cls == CLS_I) || (cls == CLS_SB);
  assign uses_rs2 = (cls == CLS_R) || (cls == CLS_SB);
  assign need_rs1 = uses_rs1 && (rs1 != '0);
  assign need_rs2 = uses_rs2 && (rs2 != '0);
  assign illegal  = (cls == CLS_ILL);

endmodule

// File: rtl/regfile_read_sched.sv
// Operand-fetch sequencer for one RV32I instruction over a single synchronous
// register-file read port. Define REGFILE_READ_SCHED_BYPASS_EN to forward a
// same-cycle writeback instead of stalling the read.
module regfile_read_sched #(
  parameter int WORD_SIZE  = regfile_sched_pkg::WORD_SIZE,
  parameter int REG_ADDR_W = regfile_sched_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [WORD_SIZE-1:0]  instruction,
  output logic                  rf_ren,
  output logic [REG_ADDR_W-1:0] rf_raddr,
  input  logic [WORD_SIZE-1:0]  rf_rdata,
  output logic                  rf_wen,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [WORD_SIZE-1:0]  rf_wdata,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [WORD_SIZE-1:0]  wb_data,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [WORD_SIZE-1:0]  op_rs1_val,
  output logic [WORD_SIZE-1:0]  op_rs2_val,
  output logic [REG_ADDR_W-1:0] op_rd,
  output logic [WORD_SIZE-1:0]  op_instr,
  output logic                  op_illegal
);

  import regfile_sched_pkg::*;

  sched_state_t          state;
  sched_state_t          state_next;

  logic [WORD_SIZE-1:0]  dec_word;
  instr_class_t          dec_cls;
  logic [REG_ADDR_W-1:0] dec_rs1;
  logic [REG_ADDR_W-1:0] dec_rs2;
  logic [REG_ADDR_W-1:0] dec_rd;
  logic                  dec_need_rs1;
  logic                  dec_need_rs2;
  logic                  dec_illegal;

  logic                  rd_cycle;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic                  hazard;
  logic                  stall;
  logic [WORD_SIZE-1:0]  cap_data;

  // The incoming word is decoded while idle; afterwards the latched copy drives the decode.
  assign dec_word = (state == IDLE) ? instruction : op_instr;

  instr_field_decode u_decode (
    .instruction (dec_word),
    .cls         (dec_cls),
    .rs1         (dec_rs1),
    .rs2         (dec_rs2),
    .rd          (dec_rd),
    .need_rs1    (dec_need_rs1),
    .need_rs2    (dec_need_rs2),
    .illegal     (dec_illegal)
  );

  assign rd_cycle = (state == RS1_RD) || (state == RS2_RD);
  assign rd_addr  = (state == RS1_RD) ? dec_rs1 : dec_rs2;
  assign hazard   = rd_cycle && wb_valid && (wb_rd == rd_addr);

`ifdef REGFILE_READ_SCHED_BYPASS_EN
  logic                 byp_hit;
  logic [WORD_SIZE-1:0] byp_data;

  assign stall = 1'b0;

  // The RAM returns pre-write data on a read-during-write, so the colliding
  // writeback value is held for the capture cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      byp_hit  <= 1'b0;
      byp_data <= '0;
    end else begin
      byp_hit  <= hazard;
      byp_data <= wb_data;
    end
  end

  assign cap_data = byp_hit ? byp_data : rf_rdata;
`else
  // Without forwarding, the read is withheld until the colliding write has landed.
  assign stall    = hazard;
  assign cap_data = rf_rdata;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (instr_valid) begin
          if (dec_need_rs1)      state_next = RS1_RD;
          else if (dec_need_rs2) state_next = RS2_RD;
          else                   state_next = OUT;
        end
      end
      RS1_RD:  if (!stall) state_next = RS1_CAP;
      RS1_CAP: state_next = dec_need_rs2 ? RS2_RD : OUT;
      RS2_RD:  if (!stall) state_next = RS2_CAP;
      RS2_CAP: state_next = OUT;
      OUT:     if (op_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    rf_ren      = 1'b0;
    rf_raddr    = '0;
    op_valid    = 1'b0;
    case (state)
      IDLE:   instr_ready = !reset;
      RS1_RD: begin
        rf_ren   = !stall && !reset;
        rf_raddr = dec_rs1;
      end
      RS2_RD: begin
        rf_ren   = !stall && !reset;
        rf_raddr = dec_rs2;
      end
      OUT:    op_valid = 1'b1;
      default: ;
    endcase
  end

  // Writes to x0 are dropped here so the register file needs no special case.
  assign rf_wen   = wb_valid && (wb_rd != '0) && !reset;
  assign rf_waddr = wb_rd;
  assign rf_wdata = wb_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      op_instr   <= '0;
      op_rs1_val <= '0;
      op_rs2_val <= '0;
      op_rd      <= '0;
      op_illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            op_instr   <= instruction;
            op_rs1_val <= '0;
            op_rs2_val <= '0;
            op_rd      <= class_has_rd(dec_cls) ? dec_rd : '0;
            op_illegal <= dec_illegal;
          end
        end
        RS1_CAP: op_rs1_val <= cap_data;
        RS2_CAP: op_rs2_val <= cap_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_read_sched.sv
// Self-checking bench for regfile_read_sched: behavioural register file,
// table-driven instruction vectors with a scoreboard queue, and directed
// sequences for hazard, back-pressure, writeback and mid-operation reset.
module tb_regfile_read_sched;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic        rf_ren;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_rs1_val;
  logic [31:0] op_rs2_val;
  logic [4:0]  op_rd;
  logic [31:0] op_instr;
  logic        op_illegal;

  regfile_read_sched dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instruction (instruction),
    .rf_ren      (rf_ren),
    .rf_raddr    (rf_raddr),
    .rf_rdata    (rf_rdata),
    .rf_wen      (rf_wen),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_rs1_val  (op_rs1_val),
    .op_rs2_val  (op_rs2_val),
    .op_rd       (op_rd),
    .op_instr    (op_instr),
    .op_illegal  (op_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: synchronous read, old data on read-during-write.
  logic [31:0] ram [32];
  logic [31:0] rdata_q;
  initial begin
    for (int i = 0; i < 32; i++) ram[i] = '0;
    rdata_q = '0;
  end
  always @(posedge clk) begin
    if (rf_wen) ram[rf_waddr] <= rf_wdata;
    if (rf_ren) rdata_q <= ram[rf_raddr];
  end
  assign rf_rdata = rdata_q;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        ill;
    int          lat;
    int          nreads;
  } vec_t;

  vec_t        vecs [12];
  vec_t        sb_q [$];
  logic [4:0]  raddr_log [$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, opc};
  endfunction

  function automatic logic [31:0] enc_sb(input logic [6:0] opc, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b010, 5'b00101, opc};
  endfunction

  function automatic logic [31:0] enc_u(input logic [6:0] opc, input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, opc};
  endfunction

  task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    wb_valid = 1'b1;
    wb_rd    = addr;
    wb_data  = data;
    @(negedge clk);
    wb_valid = 1'b0;
  endtask

  // Drive one instruction with op_ready high; expected record goes through the scoreboard.
  task automatic run_vec(input vec_t v, input string tag);
    vec_t exp;
    int   lat;
    int   nreads;
    sb_q.push_back(v);
    raddr_log.delete();
    @(negedge clk);
    instruction = v.instr;
    instr_valid = 1'b1;
    op_ready    = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    lat    = 1;
    nreads = 0;
    while (!op_valid && lat < 20) begin
      if (rf_ren) begin
        nreads++;
        raddr_log.push_back(rf_raddr);
      end
      @(negedge clk);
      lat++;
    end
    exp = sb_q.pop_front();
    check({tag, "_latency"}, lat, exp.lat);
    check({tag, "_reads"}, nreads, exp.nreads);
    check({tag, "_rs1"}, op_rs1_val, exp.rs1);
    check({tag, "_rs2"}, op_rs2_val, exp.rs2);
    check({tag, "_rd"}, {27'b0, op_rd}, {27'b0, exp.rd});
    check({tag, "_illegal"}, {31'b0, op_illegal}, {31'b0, exp.ill});
    check({tag, "_instr"}, op_instr, exp.instr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    int   lat;
    int   exp_lat;
    logic exp_ren;
    vec_t v;

    reset       = 1'b1;
    instr_valid = 1'b0;
    instruction = '0;
    wb_valid    = 1'b0;
    wb_rd       = '0;
    wb_data     = '0;
    op_ready    = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_op_valid", {31'b0, op_valid}, 32'd0);
    check("rst_rf_ren", {31'b0, rf_ren}, 32'd0);
    check("rst_rf_wen", {31'b0, rf_wen}, 32'd0);
    check("rst_op_rs1", op_rs1_val, 32'd0);
    check("rst_op_instr", op_instr, 32'd0);
    check("rst_op_illegal", {31'b0, op_illegal}, 32'd0);
    reset = 1'b0;
    #1;
    check("rst_instr_ready", {31'b0, instr_ready}, 32'd1);

    wb_write(5'd1,  32'h11);
    wb_write(5'd2,  32'h22);
    wb_write(5'd5,  32'h55);
    wb_write(5'd10, 32'hA0A0);
    wb_write(5'd31, 32'hDEADBEEF);

    vecs[0]  = '{32'h002081B3, 32'h11, 32'h22, 5'd3, 1'b0, 5, 2};
    vecs[1]  = '{32'h00700293, 32'h0, 32'h0, 5'd5, 1'b0, 1, 0};
    vecs[2]  = '{enc_u(7'b0110111, 5'd1, 20'h12345), 32'h0, 32'h0, 5'd1, 1'b0, 1, 0};
    vecs[3]  = '{32'h002081FF, 32'h0, 32'h0, 5'd0, 1'b1, 1, 0};
    vecs[4]  = '{enc_sb(7'b0100011, 5'd10, 5'd31), 32'hA0A0, 32'hDEADBEEF, 5'd0, 1'b0, 5, 2};
    vecs[5]  = '{enc_sb(7'b1100011, 5'd0, 5'd5), 32'h0, 32'h55, 5'd0, 1'b0, 3, 1};
    vecs[6]  = '{enc_i(7'b0000011, 5'd7, 5'd31, 12'h003), 32'hDEADBEEF, 32'h0, 5'd7, 1'b0, 3, 1};
    vecs[7]  = '{enc_u(7'b1101111, 5'd1, 20'hABCDE), 32'h0, 32'h0, 5'd1, 1'b0, 1, 0};
    vecs[8]  = '{enc_u(7'b0010111, 5'd9, 20'h00FFF), 32'h0, 32'h0, 5'd9, 1'b0, 1, 0};
    vecs[9]  = '{enc_i(7'b1100111, 5'd4, 5'd2, 12'h010), 32'h22, 32'h0, 5'd4, 1'b0, 3, 1};
    vecs[10] = '{enc_r(5'd6, 5'd1, 5'd0), 32'h11, 32'h0, 5'd6, 1'b0, 3, 1};
    vecs[11] = '{enc_r(5'd8, 5'd0, 5'd0), 32'h0, 32'h0, 5'd8, 1'b0, 1, 0};

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      if (i == 0 && raddr_log.size() == 2) begin
        check("add_raddr_first", {27'b0, raddr_log[0]}, 32'd1);
        check("add_raddr_second", {27'b0, raddr_log[1]}, 32'd2);
      end else if (i == 0) begin
        check("add_raddr_count", raddr_log.size(), 32'd2);
      end
    end

    // Back-pressure: hold op_ready low in OUT while a second instruction is offered.
    @(negedge clk);
    instruction = 32'h002081B3;
    instr_valid = 1'b1;
    op_ready    = 1'b0;
    @(negedge clk);
    instr_valid = 1'b0;
    lat = 1;
    while (!op_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp_latency", lat, 32'd5);
    instruction = enc_u(7'b0110111, 5'd9, 20'h55555);
    instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("bp_op_valid", {31'b0, op_valid}, 32'd1);
      check("bp_instr_ready", {31'b0, instr_ready}, 32'd0);
      check("bp_rs1", op_rs1_val, 32'h11);
      check("bp_rs2", op_rs2_val, 32'h22);
      check("bp_rd", {27'b0, op_rd}, 32'd3);
      check("bp_instr", op_instr, 32'h002081B3);
      @(negedge clk);
    end
    instr_valid = 1'b0;
    op_ready    = 1'b1;
    @(negedge clk);
    check("bp_release_ready", {31'b0, instr_ready}, 32'd1);
    check("bp_release_valid", {31'b0, op_valid}, 32'd0);
    check("bp_instr_not_taken", op_instr, 32'h002081B3);

    // Hazard: writeback to x1 during the RS1_RD cycle of add x3,x1,x2.
`ifdef REGFILE_READ_SCHED_BYPASS_EN
    exp_lat = 5;
    exp_ren = 1'b1;
`else
    exp_lat = 6;
    exp_ren = 1'b0;
`endif
    @(negedge clk);
    instruction = 32'h002081B3;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    wb_valid    = 1'b1;
    wb_rd       = 5'd1;
    wb_data     = 32'hAA;
    #1;
    check("hz_rf_wen", {31'b0, rf_wen}, 32'd1);
    check("hz_rf_ren", {31'b0, rf_ren}, {31'b0, exp_ren});
    @(negedge clk);
    wb_valid = 1'b0;
    lat = 2;
    while (!op_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("hz_latency", lat, exp_lat);
    check("hz_rs1", op_rs1_val, 32'hAA);
    check("hz_rs2", op_rs2_val, 32'h22);
    check("hz_rd", {27'b0, op_rd}, 32'd3);

    // Writeback pass-through, including the dropped x0 write.
    @(negedge clk);
    wb_valid = 1'b1;
    wb_rd    = 5'd0;
    wb_data  = 32'h1234;
    #1;
    check("wb_x0_wen", {31'b0, rf_wen}, 32'd0);
    @(negedge clk);
    wb_rd   = 5'd7;
    wb_data = 32'h77;
    #1;
    check("wb_x7_wen", {31'b0, rf_wen}, 32'd1);
    check("wb_x7_waddr", {27'b0, rf_waddr}, 32'd7);
    check("wb_x7_wdata", rf_wdata, 32'h77);
    @(negedge clk);
    wb_valid = 1'b0;
    v = '{enc_i(7'b0000011, 5'd8, 5'd7, 12'h000), 32'h77, 32'h0, 5'd8, 1'b0, 3, 1};
    run_vec(v, "after_wb");

    // Reset asserted in RS2_CAP abandons the instruction.
    @(negedge clk);
    instruction = 32'h002081B3;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rs1_before_reset", op_rs1_val, 32'hAA);
    reset    = 1'b1;
    wb_valid = 1'b1;
    wb_rd    = 5'd7;
    wb_data  = 32'hBAD;
    #1;
    check("mid_reset_wen", {31'b0, rf_wen}, 32'd0);
    @(negedge clk);
    check("mid_op_valid", {31'b0, op_valid}, 32'd0);
    check("mid_rf_ren", {31'b0, rf_ren}, 32'd0);
    check("mid_rs1", op_rs1_val, 32'd0);
    check("mid_rs2", op_rs2_val, 32'd0);
    check("mid_rd", {27'b0, op_rd}, 32'd0);
    check("mid_instr", op_instr, 32'd0);
    check("mid_illegal", {31'b0, op_illegal}, 32'd0);
    wb_valid = 1'b0;
    reset    = 1'b0;
    #1;
    check("mid_instr_ready", {31'b0, instr_ready}, 32'd1);
    v = '{enc_u(7'b0110111, 5'd12, 20'h0F0F0), 32'h0, 32'h0, 5'd12, 1'b0, 1, 0};
    run_vec(v, "post_reset");
    v = '{enc_i(7'b0010011, 5'd13, 5'd7, 12'h001), 32'h77, 32'h0, 5'd13, 1'b0, 3, 1};
    run_vec(v, "post_reset_x7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
